// File: rtl/mlb_cfg_pkg.sv
// Shared types, CRC constants and the serial CRC step for the MAC config loader.
package mlb_cfg_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, VERIFY, DONE} cfg_state_t;

    localparam int unsigned      CRC_W      = 16;
    localparam logic [CRC_W-1:0] CRC16_POLY = 16'h1021;
    localparam logic [CRC_W-1:0] CRC16_INIT = 16'hFFFF;

    function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] crc,
                                                  input logic             bit_in);
        logic fb;
        fb = crc[CRC_W-1] ^ bit_in;
        return {crc[CRC_W-2:0], 1'b0} ^ (fb ? CRC16_POLY : '0);
    endfunction

endpackage

// File: rtl/cfg_crc_serial.sv
// Bit-serial CRC-16-CCITT accumulator; clr and reset both return it to all-ones.
module cfg_crc_serial
    import mlb_cfg_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic             i_bit_in,
    output logic [CRC_W-1:0] o_crc
);

    logic [CRC_W-1:0] r_crc;

    always_ff @(posedge i_clk) begin
        if (i_reset || i_clr) begin
            r_crc <= CRC16_INIT;
        end else if (i_en) begin
            r_crc <= crc_step(r_crc, i_bit_in);
        end
    end

    assign o_crc = r_crc;

endmodule

// File: rtl/mac_config_loader.sv
// Serialises parallel config words LSB-first into a MAC config chain, with an optional
// rotate-and-CRC verify pass over the returned bits.
module mac_config_loader
    import mlb_cfg_pkg::*;
#(
    parameter int unsigned CHAIN_LEN = 64,
    parameter int unsigned WORD_W    = 8
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic              i_verify_en,
    input  logic [WORD_W-1:0] i_word_in,
    input  logic              i_word_valid,
    output logic              o_word_ready,
    output logic              o_config_en,
    output logic              o_config_in,
    input  logic              i_config_out,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_verify_err,
    output logic [CRC_W-1:0]  o_sent_crc
);

    localparam int unsigned NUM_WORDS = (CHAIN_LEN + WORD_W - 1) / WORD_W;
    localparam int unsigned CNT_W     = $clog2(CHAIN_LEN + 1);
    localparam int unsigned WCNT_W    = $clog2(NUM_WORDS + 1);
    localparam int unsigned BIDX_W    = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(CHAIN_LEN - 1);
    localparam logic [BIDX_W-1:0] LAST_BIDX = BIDX_W'(WORD_W - 1);
    localparam logic [WCNT_W-1:0] WORDS_MAX = WCNT_W'(NUM_WORDS);

    cfg_state_t        r_state, w_state_d;
    logic [WORD_W-1:0] r_buf;
    logic              r_buf_valid, w_buf_valid_d;
    logic [BIDX_W-1:0] r_bidx;
    logic [CNT_W-1:0]  r_bit_cnt;
    logic [WCNT_W-1:0] r_word_cnt;
    logic              r_verify_en;
    logic              r_verify_err;
    logic              r_config_en, w_config_en_d;

    logic              w_start, w_shift, w_word_end, w_chain_end, w_ready, w_accept;
    logic              w_verifying;
    logic [CRC_W-1:0]  w_sent_crc, w_rx_crc, w_rx_crc_next;

    assign w_start     = (r_state == IDLE) && i_start;
    assign w_shift     = (r_state == LOAD) && r_buf_valid;
    assign w_verifying = (r_state == VERIFY);
    assign w_word_end  = (r_bidx == LAST_BIDX);
    assign w_chain_end = (r_bit_cnt == LAST_BIT);
    // Refill while the final bit of the current word is leaving, so streaming has no bubble.
    assign w_ready     = (r_state == LOAD) && (r_word_cnt != WORDS_MAX) &&
                         (!r_buf_valid || (w_shift && w_word_end));
    assign w_accept    = w_ready && i_word_valid;

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            IDLE:    if (i_start) w_state_d = LOAD;
            LOAD:    if (w_shift && w_chain_end) w_state_d = r_verify_en ? VERIFY : DONE;
            VERIFY:  if (w_chain_end) w_state_d = DONE;
            DONE:    w_state_d = IDLE;
            default: w_state_d = IDLE;
        endcase
    end

    always_comb begin
        w_buf_valid_d = r_buf_valid;
        // Chain end also empties the buffer: leftover bits of a partial last word are dropped.
        if (w_shift && (w_word_end || w_chain_end)) w_buf_valid_d = 1'b0;
        if (w_accept) w_buf_valid_d = 1'b1;
        w_config_en_d = ((w_state_d == LOAD) && w_buf_valid_d) || (w_state_d == VERIFY);
    end

    always_comb begin
        o_config_in = 1'b0;
        if (w_shift) begin
            o_config_in = r_buf[r_bidx];
        end else if (w_verifying) begin
            o_config_in = i_config_out;
        end
    end

    assign w_rx_crc_next = crc_step(w_rx_crc, i_config_out);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= IDLE;
            r_buf        <= '0;
            r_buf_valid  <= 1'b0;
            r_bidx       <= '0;
            r_bit_cnt    <= '0;
            r_word_cnt   <= '0;
            r_verify_en  <= 1'b0;
            r_verify_err <= 1'b0;
            r_config_en  <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_buf_valid <= w_buf_valid_d;
            r_config_en <= w_config_en_d;
            if (w_start) begin
                r_verify_en  <= i_verify_en;
                r_verify_err <= 1'b0;
                r_word_cnt   <= '0;
                r_bit_cnt    <= '0;
            end
            if (w_accept) begin
                r_buf      <= i_word_in;
                r_bidx     <= '0;
                r_word_cnt <= r_word_cnt + 1'b1;
            end else if (w_shift) begin
                r_bidx <= r_bidx + 1'b1;
            end
            // Counter clears on the last LOAD bit so VERIFY reuses it from zero.
            if (w_shift || w_verifying) begin
                r_bit_cnt <= w_chain_end ? '0 : r_bit_cnt + 1'b1;
            end
            if (w_verifying && w_chain_end) begin
                r_verify_err <= (w_rx_crc_next != w_sent_crc);
            end
        end
    end

    cfg_crc_serial u_sent_crc (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_clr    (w_start),
        .i_en     (w_shift),
        .i_bit_in (o_config_in),
        .o_crc    (w_sent_crc)
    );

    cfg_crc_serial u_rx_crc (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_clr    (w_start),
        .i_en     (w_verifying),
        .i_bit_in (i_config_out),
        .o_crc    (w_rx_crc)
    );

    assign o_word_ready = w_ready;
    assign o_config_en  = r_config_en;
    assign o_busy       = (r_state == LOAD) || (r_state == VERIFY);
    assign o_done       = (r_state == DONE);
    assign o_verify_err = r_verify_err;
    assign o_sent_crc   = w_sent_crc;

endmodule

// File: tb/tb_mac_config_loader.sv
// Bench: two loaders (64-bit and 20-bit chains) driving behavioural shift-register chains.
module tb_mac_config_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_reset, a_start, a_ven, a_valid, a_ready, a_en, a_cin, a_cout;
    logic        a_busy, a_done, a_err;
    logic [7:0]  a_word;
    logic [15:0] a_crc;
    logic [63:0] chain_a = '0;
    logic [63:0] flip_a  = '0;

    logic        b_reset, b_start, b_ven, b_valid, b_ready, b_en, b_cin, b_cout;
    logic        b_busy, b_done, b_err;
    logic [7:0]  b_word;
    logic [15:0] b_crc;
    logic [19:0] chain_b = '0;

    mac_config_loader #(.CHAIN_LEN(64), .WORD_W(8)) u_dut_a (
        .i_clk        (clk),
        .i_reset      (a_reset),
        .i_start      (a_start),
        .i_verify_en  (a_ven),
        .i_word_in    (a_word),
        .i_word_valid (a_valid),
        .o_word_ready (a_ready),
        .o_config_en  (a_en),
        .o_config_in  (a_cin),
        .i_config_out (a_cout),
        .o_busy       (a_busy),
        .o_done       (a_done),
        .o_verify_err (a_err),
        .o_sent_crc   (a_crc)
    );

    mac_config_loader #(.CHAIN_LEN(20), .WORD_W(8)) u_dut_b (
        .i_clk        (clk),
        .i_reset      (b_reset),
        .i_start      (b_start),
        .i_verify_en  (b_ven),
        .i_word_in    (b_word),
        .i_word_valid (b_valid),
        .o_word_ready (b_ready),
        .o_config_en  (b_en),
        .o_config_in  (b_cin),
        .i_config_out (b_cout),
        .o_busy       (b_busy),
        .o_done       (b_done),
        .o_verify_err (b_err),
        .o_sent_crc   (b_crc)
    );

    // Chain head enters at the MSB; the tail (bit 0) feeds config_out.
    always @(posedge clk) begin
        chain_a <= (a_en ? {a_cin, chain_a[63:1]} : chain_a) ^ flip_a;
        if (b_en) chain_b <= {b_cin, chain_b[19:1]};
    end
    assign a_cout = chain_a[0];
    assign b_cout = chain_b[0];

    logic cnt_clr = 1'b0;
    logic prev_en = 1'b0;
    int   en_cnt, busy_cnt, idle_cnt, run, max_run, done_cnt, done_ok, acc_b, en_b_cnt;

    always @(posedge clk) begin
        if (cnt_clr) begin
            en_cnt <= 0; busy_cnt <= 0; idle_cnt <= 0; run <= 0; max_run <= 0;
            done_cnt <= 0; done_ok <= 0; acc_b <= 0; en_b_cnt <= 0;
        end else begin
            if (a_en) en_cnt <= en_cnt + 1;
            if (a_busy) busy_cnt <= busy_cnt + 1;
            if (a_busy && !a_en) idle_cnt <= idle_cnt + 1;
            if (a_en) begin
                run <= run + 1;
                if (run + 1 > max_run) max_run <= run + 1;
            end else begin
                run <= 0;
            end
            if (a_done) begin
                done_cnt <= done_cnt + 1;
                done_ok  <= prev_en ? 1 : 0;
            end
            if (b_valid && b_ready) acc_b <= acc_b + 1;
            if (b_en) en_b_cnt <= en_b_cnt + 1;
        end
        prev_en <= a_en;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] tb_crc(input logic [63:0] d, input int n);
        logic [15:0] c;
        logic        fb;
        c = 16'hFFFF;
        for (int i = 0; i < n; i++) begin
            fb = c[15] ^ d[i];
            c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
        end
        return c;
    endfunction

    task automatic clear_counters();
        @(negedge clk); cnt_clr = 1'b1;
        @(negedge clk); cnt_clr = 1'b0;
    endtask

    task automatic start_a(input logic ven);
        @(negedge clk); a_start = 1'b1; a_ven = ven;
        @(negedge clk); a_start = 1'b0; a_ven = 1'b0;
    endtask

    task automatic feed_a(input logic [63:0] d, input int gap_word, input int gap_len);
        for (int i = 0; i < 8; i++) begin
            int t;
            if (i == gap_word && gap_len > 0) begin
                a_valid = 1'b0;
                t = 0;
                while (!a_ready && t < 200) begin @(negedge clk); t++; end
                repeat (gap_len) @(negedge clk);
            end
            a_word  = d[8*i +: 8];
            a_valid = 1'b1;
            t = 0;
            while (!a_ready && t < 200) begin @(negedge clk); t++; end
            chk($sformatf("feed word%0d ready", i), 64'(a_ready), 64'd1);
            @(negedge clk);
        end
        a_valid = 1'b0;
        a_word  = '0;
    endtask

    task automatic wait_done_a(input string name);
        int t;
        t = 0;
        while (!a_done && t < 400) begin @(negedge clk); t++; end
        chk({name, " done seen"}, 64'(a_done), 64'd1);
    endtask

    typedef struct {
        logic [63:0] data;
        int          gap_word;
        int          gap_len;
        logic        verify;
        int          exp_busy;
        int          exp_idle;
        int          exp_run;
        int          exp_en;
    } vec_t;

    vec_t vecs[4];

    initial begin
        a_reset = 1'b1; a_start = 1'b0; a_ven = 1'b0; a_valid = 1'b0; a_word = '0;
        b_reset = 1'b1; b_start = 1'b0; b_ven = 1'b0; b_valid = 1'b0; b_word = '0;

        vecs[0] = '{64'h0807060504030201, -1, 0, 1'b0,  65, 1,  64,  64};
        vecs[1] = '{64'h0807060504030201,  3, 3, 1'b0,  68, 4,  40,  64};
        vecs[2] = '{64'hDEADBEEF0F1E2D3C, -1, 0, 1'b1, 129, 1, 128, 128};
        vecs[3] = '{64'hFFFF0000AAAA5555,  1, 5, 1'b1, 134, 6, 120, 128};

        repeat (3) @(negedge clk);
        a_reset = 1'b0; b_reset = 1'b0;
        @(negedge clk);
        chk("rst ready", 64'(a_ready), 64'd0);
        chk("rst cfg_en", 64'(a_en), 64'd0);
        chk("rst cfg_in", 64'(a_cin), 64'd0);
        chk("rst busy", 64'(a_busy), 64'd0);
        chk("rst done", 64'(a_done), 64'd0);
        chk("rst verr", 64'(a_err), 64'd0);
        chk("rst crc", 64'(a_crc), 64'hFFFF);
        chk("rst b busy", 64'(b_busy), 64'd0);
        chk("rst b crc", 64'(b_crc), 64'hFFFF);

        for (int k = 0; k < 4; k++) begin
            string tag;
            tag = $sformatf("vec%0d", k);
            clear_counters();
            start_a(vecs[k].verify);
            chk({tag, " busy after start"}, 64'(a_busy), 64'd1);
            feed_a(vecs[k].data, vecs[k].gap_word, vecs[k].gap_len);
            wait_done_a(tag);
            chk({tag, " chain"}, chain_a, vecs[k].data);
            chk({tag, " sent_crc"}, 64'(a_crc), 64'(tb_crc(vecs[k].data, 64)));
            chk({tag, " verr"}, 64'(a_err), 64'd0);
            chk({tag, " busy at done"}, 64'(a_busy), 64'd0);
            @(negedge clk);
            chk({tag, " busy cycles"}, 64'(busy_cnt), 64'(vecs[k].exp_busy));
            chk({tag, " stall cycles"}, 64'(idle_cnt), 64'(vecs[k].exp_idle));
            chk({tag, " longest cfg_en run"}, 64'(max_run), 64'(vecs[k].exp_run));
            chk({tag, " cfg_en cycles"}, 64'(en_cnt), 64'(vecs[k].exp_en));
            chk({tag, " done pulses"}, 64'(done_cnt), 64'd1);
            chk({tag, " done after last shift"}, 64'(done_ok), 64'd1);
        end

        // Partial last word on a 20-bit chain; a fourth word is offered but must not be taken.
        begin
            logic [7:0] wb [4];
            int wi, t;
            wb[0] = 8'hAB; wb[1] = 8'hCD; wb[2] = 8'hFE; wb[3] = 8'h77;
            clear_counters();
            @(negedge clk); b_start = 1'b1;
            @(negedge clk); b_start = 1'b0;
            wi = 0; t = 0;
            b_word = wb[0]; b_valid = 1'b1;
            while (!b_done && t < 100) begin
                logic acc;
                acc = b_ready;
                @(negedge clk);
                if (acc && wi < 3) begin wi++; b_word = wb[wi]; end
                t++;
            end
            chk("short done seen", 64'(b_done), 64'd1);
            chk("short chain", 64'(chain_b), 64'h0ECDAB);
            chk("short sent_crc", 64'(b_crc), 64'(tb_crc(64'h0ECDAB, 20)));
            chk("short ready at done", 64'(b_ready), 64'd0);
            @(negedge clk);
            b_valid = 1'b0;
            chk("short words accepted", 64'(acc_b), 64'd3);
            chk("short cfg_en cycles", 64'(en_b_cnt), 64'd20);
        end

        // Corrupt one chain bit mid-verify; sticky error until the next start.
        clear_counters();
        start_a(1'b1);
        feed_a(64'h0807060504030201, -1, 0);
        repeat (18) @(negedge clk);
        chk("flip lands in verify", 64'(a_en && a_busy), 64'd1);
        flip_a = 64'h20;
        @(negedge clk);
        flip_a = '0;
        wait_done_a("flip");
        chk("flip verr at done", 64'(a_err), 64'd1);
        repeat (3) @(negedge clk);
        chk("flip verr sticky", 64'(a_err), 64'd1);
        start_a(1'b0);
        chk("verr cleared by start", 64'(a_err), 64'd0);
        feed_a(64'h0807060504030201, -1, 0);
        wait_done_a("reload");
        chk("reload chain", chain_a, 64'h0807060504030201);
        chk("reload verr", 64'(a_err), 64'd0);

        // Reset at shift 30 of a load, with start asserted in the same cycle.
        begin
            logic [63:0] d;
            int wi;
            d = 64'h1122334455667788;
            clear_counters();
            start_a(1'b0);
            wi = 0;
            a_word = d[7:0]; a_valid = 1'b1;
            for (int c = 0; c < 200; c++) begin
                logic acc;
                acc = a_ready;
                @(negedge clk);
                if (acc && wi < 7) begin wi++; a_word = d[8*wi +: 8]; end
                if (en_cnt == 30) break;
            end
            chk("abort reached shift 30", 64'(en_cnt), 64'd30);
            a_reset = 1'b1; a_start = 1'b1; a_valid = 1'b0;
            @(negedge clk);
            a_reset = 1'b0; a_start = 1'b0;
            chk("abort cfg_en", 64'(a_en), 64'd0);
            chk("abort busy", 64'(a_busy), 64'd0);
            chk("abort ready", 64'(a_ready), 64'd0);
            chk("abort crc", 64'(a_crc), 64'hFFFF);
            @(negedge clk);
            chk("reset beats start", 64'(a_busy), 64'd0);

            clear_counters();
            start_a(1'b0);
            feed_a(64'h0807060504030201, -1, 0);
            a_start = 1'b1; a_ven = 1'b1;
            @(negedge clk);
            a_start = 1'b0; a_ven = 1'b0;
            wait_done_a("after abort");
            chk("after abort chain", chain_a, 64'h0807060504030201);
            chk("after abort crc", 64'(a_crc), 64'(tb_crc(64'h0807060504030201, 64)));
            @(negedge clk);
            chk("start while busy ignored", 64'(busy_cnt), 64'd65);
            chk("no second load", 64'(a_busy), 64'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
